// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank:
// register offsets, CTRL fields, mode codes, FSM states.
package timer_bank_pkg;

  localparam int CHW = 3;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_PSC  = 8;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_FREE    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  // Mode 11 aliases one-shot.
  function automatic logic is_oneshot(input logic [1:0] m);
    return (m == MODE_ONESHOT) || (m == 2'b11);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS,
// prescaler and the IDLE/LOAD/CNT/INT sequencer.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  reg_sel,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t state, state_nxt;

  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_cnt;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             pending;

  logic tick, free, cnt_last, cnt_max;
  logic do_load, run, do_tick, hw_set, hw_clr_en;
  logic wr_ctrl, wr_preset, w1c;
  logic din_unused;

  assign din_unused = ^din;

  assign tick     = (psc_cnt == psc);
  assign free     = (mode == MODE_FREE);
  assign cnt_last = (count <= CNT_W'(1));
  assign cnt_max  = &count;

  assign wr_ctrl   = we && (reg_sel == REG_CTRL);
  assign wr_preset = we && (reg_sel == REG_PRESET);
  assign w1c       = we && (reg_sel == REG_STATUS) && din[0];

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Sequencer next-state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (en) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_CNT;
      ST_CNT: begin
        if (!en)
          state_nxt = ST_IDLE;
        else if (tick && !free && cnt_last)
          state_nxt = ST_INT;
      end
      ST_INT:
        state_nxt = is_oneshot(mode) ? ST_IDLE : ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer outputs: load, tick and expiry strobes
  always_comb begin
    do_load   = (state == ST_LOAD);
    run       = (state == ST_CNT) && en;
    do_tick   = run && tick;
    hw_set    = do_tick && (free ? cnt_max : cnt_last);
    hw_clr_en = (state == ST_INT) && is_oneshot(mode);
  end

  // Software-visible registers; software CTRL write beats hw EN clear
  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      mode    <= 2'b00;
      im      <= 1'b0;
      psc     <= '0;
      preset  <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en   <= din[CTRL_EN];
        mode <= din[CTRL_MODE +: 2];
        im   <= din[CTRL_IM];
        psc  <= din[CTRL_PSC +: PSC_W];
      end else if (hw_clr_en) begin
        en <= 1'b0;
      end
      if (wr_preset) preset <= din[CNT_W-1:0];
      if (hw_set)   pending <= 1'b1;
      else if (w1c) pending <= 1'b0;
    end
  end

  // Counter and prescaler datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      psc_cnt <= '0;
    end else if (do_load) begin
      count   <= preset;
      psc_cnt <= '0;
    end else if (run) begin
      if (tick) begin
        psc_cnt <= '0;
        if (free)          count <= count + CNT_W'(1);
        else if (cnt_last) count <= '0;
        else               count <= count - CNT_W'(1);
      end else begin
        psc_cnt <= psc_cnt + PSC_W'(1);
      end
    end
  end

  // Register read mux, unused bits zero
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_EN]          = en;
        rdata[CTRL_MODE +: 2]   = mode;
        rdata[CTRL_IM]          = im;
        rdata[CTRL_PSC +: PSC_W] = psc;
      end
      REG_PRESET: rdata[CNT_W-1:0] = preset;
      REG_COUNT:  rdata[CNT_W-1:0] = count;
      REG_STATUS: rdata[0]         = pending;
      default:    rdata = '0;
    endcase
  end

  assign irq = pending & im;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel timer bank: channel decode,
// write gating, read mux and interrupt reduction.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       addr,
  input  logic              we,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic [CHW-1:0] chan;
  logic [1:0]     reg_sel;
  logic [31:0]    rdata [NUM_CH];
  logic           addr_unused;

  assign chan        = addr[CHW+1:2];
  assign reg_sel     = addr[1:0];
  assign addr_unused = ^addr[29:CHW+2];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W (CNT_W),
      .PSC_W (PSC_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .reg_sel (reg_sel),
      .we      (we && (chan == CHW'(i))),
      .din     (din),
      .rdata   (rdata[i]),
      .irq     (irq[i])
    );
  end

  // Read mux; unpopulated channels read zero
  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (chan == CHW'(i)) dout = rdata[i];
  end

  assign irq_any = |irq;

endmodule
